// File: rtl/iir_la_mc.sv
// Multi-channel first-order look-ahead IIR filter: two-stage shared pipeline with
// per-channel x/w/y history and selectable saturate-or-wrap output reduction.
module iir_la_mc #(
    parameter int W   = 10,
    parameter int CH  = 4,
    parameter int SAT = 1,
    localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                CLK_i,
    input  logic                RST_N_i,
    input  logic                CLR_i,
    input  logic                VIN_i,
    input  logic [CW-1:0]       CH_i,
    input  logic signed [W-1:0] DIN_i,
    input  logic signed [W-1:0] B0_i,
    input  logic signed [W-1:0] B1_i,
    input  logic signed [W-1:0] A1_i,
    input  logic signed [W-1:0] A1_2_i,
    output logic                VOUT_o,
    output logic [CW-1:0]       CH_o,
    output logic signed [W-1:0] DOUT_o
);

    // Three guard bits hold any sum of up to three shifted products without loss.
    localparam int SW = W + 3;
    localparam logic signed [SW-1:0] MAXV = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic signed [SW-1:0] mul_sh(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = a * b;
        p = p >>> (W - 1);
        return p[SW-1:0];
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
        logic signed [W-1:0] r;
        if ((SAT != 0) && (v > MAXV)) r = MAXV[W-1:0];
        else if ((SAT != 0) && (v < MINV)) r = MINV[W-1:0];
        else r = v[W-1:0];
        return r;
    endfunction

    logic signed [W-1:0] r_xh  [CH];
    logic signed [W-1:0] r_wh  [CH];
    logic signed [W-1:0] r_y1h [CH];
    logic signed [W-1:0] r_y2h [CH];

    logic                r_s1_v;
    logic [CW-1:0]       r_s1_ch;
    logic signed [W-1:0] r_s1_w;
    logic signed [W-1:0] r_s1_wp;
    logic                r_vout;
    logic [CW-1:0]       r_cho;
    logic signed [W-1:0] r_dout;

    logic                 w_ch_ok;
    logic                 w_acc;
    logic [CW-1:0]        w_idx;
    logic signed [SW-1:0] w_sum1;
    logic signed [W-1:0]  w_w;
    logic signed [SW-1:0] w_wext;
    logic signed [SW-1:0] w_sum2;
    logic signed [W-1:0]  w_y;

    // Out-of-range channels are steered to index 0 for reads but never accepted.
    assign w_ch_ok = ({1'b0, CH_i} < (CW+1)'(CH));
    assign w_acc   = VIN_i & w_ch_ok;
    assign w_idx   = w_ch_ok ? CH_i : {CW{1'b0}};

    assign w_sum1 = mul_sh(B0_i, DIN_i) + mul_sh(B1_i, r_xh[w_idx]);
    assign w_w    = sat_w(w_sum1);

    // y2h is already y[n-2] here even for back-to-back samples on one channel.
    assign w_wext = SW'(r_s1_w);
    assign w_sum2 = w_wext - mul_sh(A1_i, r_s1_wp) + mul_sh(A1_2_i, r_y2h[r_s1_ch]);
    assign w_y    = sat_w(w_sum2);

    // Pipeline, history and output registers; CLR_i clears everything and wins over VIN_i.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            for (int i = 0; i < CH; i++) begin
                r_xh[i]  <= '0;
                r_wh[i]  <= '0;
                r_y1h[i] <= '0;
                r_y2h[i] <= '0;
            end
            r_s1_v  <= 1'b0;
            r_s1_ch <= '0;
            r_s1_w  <= '0;
            r_s1_wp <= '0;
            r_vout  <= 1'b0;
            r_cho   <= '0;
            r_dout  <= '0;
        end else if (CLR_i) begin
            for (int i = 0; i < CH; i++) begin
                r_xh[i]  <= '0;
                r_wh[i]  <= '0;
                r_y1h[i] <= '0;
                r_y2h[i] <= '0;
            end
            r_s1_v  <= 1'b0;
            r_s1_ch <= '0;
            r_s1_w  <= '0;
            r_s1_wp <= '0;
            r_vout  <= 1'b0;
            r_cho   <= '0;
            r_dout  <= '0;
        end else begin
            r_s1_v <= w_acc;
            if (w_acc) begin
                r_s1_w       <= w_w;
                r_s1_wp      <= r_wh[w_idx];
                r_s1_ch      <= CH_i;
                r_xh[w_idx]  <= DIN_i;
                r_wh[w_idx]  <= w_w;
            end
            r_vout <= r_s1_v;
            if (r_s1_v) begin
                r_dout           <= w_y;
                r_cho            <= r_s1_ch;
                r_y2h[r_s1_ch]   <= r_y1h[r_s1_ch];
                r_y1h[r_s1_ch]   <= w_y;
            end
        end
    end

    assign VOUT_o = r_vout;
    assign CH_o   = r_cho;
    assign DOUT_o = r_dout;

endmodule

// File: tb/tb_iir_la_mc.sv
// Bench for iir_la_mc: a saturating 4-channel instance and a wrapping 3-channel instance
// share one stimulus stream and are checked against a per-channel arithmetic model.
module tb_iir_la_mc;

    logic              CLK_i = 1'b0;
    logic              RST_N_i = 1'b0;
    logic              CLR_i = 1'b0;
    logic              VIN_i = 1'b0;
    logic [1:0]        CH_i = 2'd0;
    logic signed [9:0] DIN_i = 10'sd0;
    logic signed [9:0] B0_i = 10'sd0, B1_i = 10'sd0, A1_i = 10'sd0, A1_2_i = 10'sd0;

    logic              vout1, vout2;
    logic [1:0]        cho1, cho2;
    logic signed [9:0] dout1, dout2;

    int total = 0;
    int bad = 0;

    iir_la_mc #(.W(10), .CH(4), .SAT(1)) dut1 (
        .CLK_i(CLK_i), .RST_N_i(RST_N_i), .CLR_i(CLR_i), .VIN_i(VIN_i), .CH_i(CH_i),
        .DIN_i(DIN_i), .B0_i(B0_i), .B1_i(B1_i), .A1_i(A1_i), .A1_2_i(A1_2_i),
        .VOUT_o(vout1), .CH_o(cho1), .DOUT_o(dout1));

    iir_la_mc #(.W(10), .CH(3), .SAT(0)) dut2 (
        .CLK_i(CLK_i), .RST_N_i(RST_N_i), .CLR_i(CLR_i), .VIN_i(VIN_i), .CH_i(CH_i),
        .DIN_i(DIN_i), .B0_i(B0_i), .B1_i(B1_i), .A1_i(A1_i), .A1_2_i(A1_2_i),
        .VOUT_o(vout2), .CH_o(cho2), .DOUT_o(dout2));

    always #5 CLK_i = ~CLK_i;

    // Reference model: index 0 = saturating 4-channel, index 1 = wrapping 3-channel.
    int m_xh[2][4], m_wh[2][4], m_y1[2][4], m_y2[2][4];
    bit p_v[2];  int p_ch[2]; int p_y[2];
    bit e_v[2];  int e_ch[2]; int e_y[2];
    int cb0, cb1, ca1, ca12;
    int nch[2] = '{4, 3};
    bit msat[2] = '{1'b1, 1'b0};

    function automatic int red(int v, bit sat);
        int t;
        if (sat) begin
            if (v > 511) return 511;
            if (v < -512) return -512;
            return v;
        end
        t = v & 1023;
        if (t >= 512) t = t - 1024;
        return t;
    endfunction

    function automatic int pr(int a, int b);
        return (a * b) >>> 9;
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) begin
                m_xh[m][c] = 0; m_wh[m][c] = 0; m_y1[m][c] = 0; m_y2[m][c] = 0;
            end
            p_v[m] = 1'b0; p_ch[m] = 0; p_y[m] = 0;
            e_v[m] = 1'b0; e_ch[m] = 0; e_y[m] = 0;
        end
    endtask

    task automatic set_coef(int b0, int b1, int a1, int a12);
        cb0 = b0; cb1 = b1; ca1 = a1; ca12 = a12;
        B0_i = 10'(b0); B1_i = 10'(b1); A1_i = 10'(a1); A1_2_i = 10'(a12);
    endtask

    // Drive one cycle of inputs, advance one rising edge, and step the model.
    task automatic tick(bit vin, int ch, int din, bit clr);
        int w, y;
        VIN_i = vin; CH_i = 2'(ch); DIN_i = 10'(din); CLR_i = clr;
        @(posedge CLK_i);
        if (clr) begin
            model_clear();
        end else begin
            for (int m = 0; m < 2; m++) begin
                e_v[m] = p_v[m];
                if (p_v[m]) begin e_y[m] = p_y[m]; e_ch[m] = p_ch[m]; end
                p_v[m] = 1'b0;
                if (vin && ch < nch[m]) begin
                    w = red(pr(cb0, din) + pr(cb1, m_xh[m][ch]), msat[m]);
                    y = red(w - pr(ca1, m_wh[m][ch]) + pr(ca12, m_y2[m][ch]), msat[m]);
                    m_y2[m][ch] = m_y1[m][ch]; m_y1[m][ch] = y;
                    m_xh[m][ch] = din; m_wh[m][ch] = w;
                    p_v[m] = 1'b1; p_ch[m] = ch; p_y[m] = y;
                end
            end
        end
        #1;
        VIN_i = 1'b0; CLR_i = 1'b0;
    endtask

    task automatic test_reset();
        RST_N_i = 1'b0;
        model_clear();
        set_coef(0, 0, 0, 0);
        #2;
        total++; if (vout1 !== 1'b0) begin bad++; $display("FAIL reset_vout1 got=%b exp=0", vout1); end
        total++; if (dout1 !== 10'sd0) begin bad++; $display("FAIL reset_dout1 got=%0d exp=0", dout1); end
        total++; if (cho1 !== 2'd0) begin bad++; $display("FAIL reset_ch1 got=%0d exp=0", cho1); end
        total++; if (vout2 !== 1'b0 || dout2 !== 10'sd0) begin bad++; $display("FAIL reset_dut2 got v=%b d=%0d exp 0/0", vout2, dout2); end
        @(negedge CLK_i);
        RST_N_i = 1'b1;
        @(negedge CLK_i);
    endtask

    task automatic test_scalar();
        set_coef(256, 0, 0, 0);
        tick(1'b1, 0, 200, 1'b0);
        total++; if (vout1 !== 1'b0) begin bad++; $display("FAIL scalar_early got=%b exp=0", vout1); end
        tick(1'b0, 0, 0, 1'b0);
        total++; if (vout1 !== 1'b1 || cho1 !== 2'd0 || dout1 !== 10'sd100)
            begin bad++; $display("FAIL scalar_out got v=%b ch=%0d d=%0d exp 1/0/100", vout1, cho1, dout1); end
        tick(1'b0, 0, 0, 1'b0);
        total++; if (vout1 !== 1'b0 || dout1 !== 10'sd100)
            begin bad++; $display("FAIL scalar_hold got v=%b d=%0d exp 0/100", vout1, dout1); end
    endtask

    task automatic test_back_to_back();
        int ex[4] = '{200, 300, 350, 375};
        set_coef(256, 0, -256, 128);
        tick(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(i < 4, 2, 400, 1'b0);
            if (i >= 1) begin
                total++; if (vout1 !== 1'b1 || cho1 !== 2'd2 || int'(dout1) !== ex[i-1])
                    begin bad++; $display("FAIL recursion1[%0d] got v=%b ch=%0d d=%0d exp 1/2/%0d", i-1, vout1, cho1, dout1, ex[i-1]); end
                total++; if (vout2 !== 1'b1 || int'(dout2) !== ex[i-1])
                    begin bad++; $display("FAIL recursion2[%0d] got v=%b d=%0d exp 1/%0d", i-1, vout2, dout2, ex[i-1]); end
            end
        end
    endtask

    task automatic test_isolation();
        int ex[6] = '{200, 0, 300, 0, 350, 0};
        tick(1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(i < 6, i % 2, (i % 2 == 0) ? 400 : 0, 1'b0);
            if (i >= 1) begin
                total++; if (vout1 !== 1'b1 || int'(cho1) !== (i-1) % 2 || int'(dout1) !== ex[i-1])
                    begin bad++; $display("FAIL isolation[%0d] got ch=%0d d=%0d exp %0d/%0d", i-1, cho1, dout1, (i-1) % 2, ex[i-1]); end
            end
        end
    endtask

    task automatic test_overflow();
        set_coef(511, 511, 0, 0);
        tick(1'b0, 0, 0, 1'b1);
        tick(1'b1, 3, 511, 1'b0);
        tick(1'b1, 3, 511, 1'b0);
        total++; if (dout1 !== 10'sd510 || vout2 !== 1'b0)
            begin bad++; $display("FAIL ovf_ch3_first got d1=%0d v2=%b exp 510/0", dout1, vout2); end
        tick(1'b1, 2, 511, 1'b0);
        total++; if (dout1 !== 10'sd511) begin bad++; $display("FAIL ovf_sat got=%0d exp=511", dout1); end
        tick(1'b1, 2, 511, 1'b0);
        total++; if (dout2 !== 10'sd510 || vout2 !== 1'b1) begin bad++; $display("FAIL ovf_wrap_first got=%0d exp=510", dout2); end
        tick(1'b0, 0, 0, 1'b0);
        total++; if (dout2 !== -10'sd4) begin bad++; $display("FAIL ovf_wrap got=%0d exp=-4", dout2); end
        total++; if (dout1 !== 10'sd511) begin bad++; $display("FAIL ovf_sat_ch2 got=%0d exp=511", dout1); end
    endtask

    task automatic test_clear_mid();
        set_coef(256, 0, -256, 128);
        tick(1'b0, 0, 0, 1'b1);
        tick(1'b1, 2, 400, 1'b0);
        tick(1'b1, 2, 400, 1'b0);
        tick(1'b0, 0, 0, 1'b0);
        total++; if (dout1 !== 10'sd300) begin bad++; $display("FAIL clr_pre got=%0d exp=300", dout1); end
        tick(1'b1, 2, 400, 1'b1);
        total++; if (vout1 !== 1'b0 || dout1 !== 10'sd0 || cho1 !== 2'd0)
            begin bad++; $display("FAIL clr_edge got v=%b d=%0d ch=%0d exp 0/0/0", vout1, dout1, cho1); end
        tick(1'b1, 2, 400, 1'b0);
        total++; if (vout1 !== 1'b0) begin bad++; $display("FAIL clr_drop got=%b exp=0", vout1); end
        tick(1'b0, 0, 0, 1'b0);
        total++; if (vout1 !== 1'b1 || dout1 !== 10'sd200) begin bad++; $display("FAIL clr_restart got=%0d exp=200", dout1); end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 2, 400, 1'b0);
        tick(1'b0, 0, 0, 1'b0);
        total++; if (dout1 !== 10'sd300) begin bad++; $display("FAIL rst_pre got=%0d exp=300", dout1); end
        tick(1'b1, 2, 400, 1'b0);
        #2;
        RST_N_i = 1'b0;
        #1;
        model_clear();
        total++; if (vout1 !== 1'b0 || dout1 !== 10'sd0 || cho1 !== 2'd0)
            begin bad++; $display("FAIL rst_async got v=%b d=%0d ch=%0d exp 0/0/0", vout1, dout1, cho1); end
        @(negedge CLK_i);
        RST_N_i = 1'b1;
        tick(1'b1, 2, 400, 1'b0);
        tick(1'b0, 0, 0, 1'b0);
        total++; if (vout1 !== 1'b1 || dout1 !== 10'sd200) begin bad++; $display("FAIL rst_restart got=%0d exp=200", dout1); end
    endtask

    task automatic test_invalid_channel();
        tick(1'b0, 0, 0, 1'b1);
        tick(1'b1, 1, 400, 1'b0);
        tick(1'b1, 3, 123, 1'b0);
        tick(1'b1, 1, 400, 1'b0);
        total++; if (vout2 !== 1'b0) begin bad++; $display("FAIL invalid_ch_vout got=%b exp=0", vout2); end
        total++; if (vout1 !== 1'b1 || cho1 !== 2'd3) begin bad++; $display("FAIL valid_ch3 got v=%b ch=%0d exp 1/3", vout1, cho1); end
        tick(1'b0, 0, 0, 1'b0);
        total++; if (vout2 !== 1'b1 || cho2 !== 2'd1 || dout2 !== 10'sd300)
            begin bad++; $display("FAIL invalid_ch_hist got ch=%0d d=%0d exp 1/300", cho2, dout2); end
    endtask

    task automatic test_random();
        int ch, din;
        for (int blk = 0; blk < 6; blk++) begin
            set_coef(int'($urandom_range(1023, 0)) - 512, int'($urandom_range(1023, 0)) - 512,
                     int'($urandom_range(1023, 0)) - 512, int'($urandom_range(1023, 0)) - 512);
            for (int i = 0; i < 250; i++) begin
                ch  = int'($urandom_range(3, 0));
                din = int'($urandom_range(1023, 0)) - 512;
                tick($urandom_range(3, 0) != 0, ch, din, $urandom_range(63, 0) == 0);
                total++; if (vout1 !== e_v[0] || int'(cho1) !== e_ch[0] || int'(dout1) !== e_y[0])
                    begin bad++; $display("FAIL rand_sat[%0d.%0d] got v=%b ch=%0d d=%0d exp %b/%0d/%0d", blk, i, vout1, cho1, dout1, e_v[0], e_ch[0], e_y[0]); end
                total++; if (vout2 !== e_v[1] || int'(cho2) !== e_ch[1] || int'(dout2) !== e_y[1])
                    begin bad++; $display("FAIL rand_wrap[%0d.%0d] got v=%b ch=%0d d=%0d exp %b/%0d/%0d", blk, i, vout2, cho2, dout2, e_v[1], e_ch[1], e_y[1]); end
            end
            tick(1'b0, 0, 0, 1'b0);
            tick(1'b0, 0, 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_scalar();
        test_back_to_back();
        test_isolation();
        test_overflow();
        test_clear_mid();
        test_reset_mid();
        test_invalid_channel();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_la_mc.md
# iir_la_mc

Parametrised, multi-channel, first-order look-ahead IIR filter core. It is the successor of the single-channel 10-bit look-ahead IIR and uses the same VIN/VOUT sample handshake. CH independent channels share one two-stage pipelined datapath, with per-channel history and selectable saturation. It sits between the sample source (data maker) and the sink in the filter lab datapath.

## Interface
- W, 10: data and coefficient width, signed two's complement; coefficients in Q1.(W-1)
- CH, 4: number of channels, ≥1; channel index width CW = max(1, clog2(CH))
- SAT, 1: 1 = saturate on overflow, 0 = wrap (keep low bits)

- CLK_i  in  1  clock, rising edge
- RST_N_i  in  1  reset, asynchronous, active-low
- CLR_i  in  1  synchronous clear of all channel history and pipeline
- VIN_i  in  1  input sample valid
- CH_i  in  CW  channel index of the input sample
- DIN_i  in  W  input sample x
- B0_i, B1_i, A1_i, A1_2_i  in  W each  coefficients b0, b1, a1, a1² (a1² is precomputed by software); must be quasi-static while VIN_i or the pipeline is active
- VOUT_o  out  1  output sample valid
- CH_o  out  CW  channel index of DOUT_o
- DOUT_o  out  W  output sample y

## Operation
- Recurrence per channel: w[n] = b0·x[n] + b1·x[n-1]; y[n] = w[n] − a1·w[n-1] + a1²·y[n-2]. This is the one-step look-ahead form of y[n] = w[n] − a1·y[n-1].
- Product rule: full 2W-bit signed product, arithmetic shift right by W-1 (floor, no rounding).
- Sums are formed at W+3 bits, then reduced to W bits by the SAT rule. With SAT=1, clamp to [−2^(W-1), 2^(W-1)−1]. With SAT=0, take the low W bits.
- w[n] is reduced to W bits by the same rule before it is used or stored.
- Per-channel history registers, all W bits: xh (x[n-1]), wh (w[n-1]), y1h (y[n-1]), y2h (y[n-2]). All are 0 after reset or CLR_i.
- CH_i ≥ CH with VIN_i=1: the sample is dropped. No history is updated and no output is produced.

## Timing
- Stage 1, at edge k where VIN_i=1 and CLR_i=0:
  - Register w[n] computed from DIN_i and xh[CH_i].
  - Register wh[CH_i] as wprev, plus CH_i and a valid bit.
  - Update xh[CH_i] ← DIN_i and wh[CH_i] ← w[n].
- Stage 2, at edge k+1 when stage-1 valid = 1:
  - Compute y = w − a1·wprev + a1²·y2h[ch] and register it to DOUT_o; set CH_o ← ch and VOUT_o ← 1.
  - Update y2h[ch] ← y1h[ch] and y1h[ch] ← y.
  - When stage-1 valid = 0: VOUT_o ← 0, and DOUT_o/CH_o hold their previous values.
- Latency: VOUT_o is high in the cycle after edge k+1, i.e. two edges after acceptance. Throughput is one sample per cycle with no stall and no backpressure.
- Back-to-back samples on the same channel (edges k-1, k) are legal. y2h read at k+1 already holds y[n-2], because the previous result was committed at edge k. This is the hazard the look-ahead form exists to remove.
- Simultaneous stage-2 commit and stage-1 accept on the same channel: the stage-1 write of xh/wh and the stage-2 write of y1h/y2h touch disjoint registers, so both take effect.
- CLR_i=1 at an edge:
  - Clear all history, stage-1 valid and VOUT_o.
  - Drop any VIN_i at that edge.
  - DOUT_o ← 0, CH_o ← 0.
  - CLR_i has priority over VIN_i.
- Reset (RST_N_i=0, any time including mid-stream):
  - Immediately VOUT_o=0, DOUT_o=0, CH_o=0, and all history and pipeline registers are 0.
  - The first sample after release behaves as n=0 with zero history.

## Test plan
- Scalar gain (W=10, CH=4): b0=256, b1=a1=a1²=0. DIN=200 on ch0 at edge k → VOUT_o=1, CH_o=0, DOUT_o=100 after edge k+1, then VOUT_o=0 the next cycle.
- Recursion, back-to-back on ch2: b0=256, b1=0, a1=−256, a1²=128, DIN=400 for 4 consecutive cycles → DOUT 200, 300, 350, 375 on consecutive cycles.
- Channel isolation: same coefficients as the recursion case, ch0 and ch1 interleaved, ch0 DIN=400, ch1 DIN=0. Output stream must read 200, 0, 300, 0, 350, 0 with CH_o alternating 0, 1.
- Overflow: b0=b1=511, DIN=511 twice on ch3, a1=a1²=0.
  - SAT=1 → DOUT 510, then 511.
  - SAT=0 build → 510, then −4.
- CLR_i and reset mid-stream: run the recursion case to 300. Assert CLR_i together with VIN_i for one edge → no output for that sample, and the next DIN=400 yields 200. Repeat with RST_N_i pulsed low mid-stream → outputs 0 immediately, restart yields 200.
- Invalid channel (CH=3 build): VIN_i=1, CH_i=3 → no VOUT_o, and no history change on channels 0–2.
